fwnoc_outport_arb: RTL and testbench

Packet-level round-robin arbiter that drains several fwnoc_fifo egress streams into one registered output link. It sits directly downstream of a set of fwnoc_fifo instances, one per input port, at each router output. It grants one FIFO at a time and holds that grant for a whole packet (wormhole), so flits from different packets never interleave on the output.

---
 rtl/fwnoc_pkg.sv | 29 ++
 rtl/fwnoc_rr_arb.sv | 34 +++
 rtl/fwnoc_outport_arb.sv | 121 ++++++++++++
 tb/tb_fwnoc_outport_arb.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwnoc_pkg.sv
// Shared fwnoc flit-format definitions and arbiter state type.
package fwnoc_pkg;

  // Header flit layout: LEN in the low byte, destination in the next byte.
  localparam int FWNOC_HDR_LEN_LSB = 0;
  localparam int FWNOC_HDR_LEN_W   = 8;
  localparam int FWNOC_HDR_DST_LSB = 8;
  localparam int FWNOC_HDR_DST_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fwnoc_arb_state_e;

  // Number of payload flits that follow a header.
  function automatic logic [FWNOC_HDR_LEN_W-1:0] fwnoc_hdr_len(
    input logic [FWNOC_HDR_DST_LSB+FWNOC_HDR_DST_W-1:0] hdr
  );
    return hdr[FWNOC_HDR_LEN_LSB +: FWNOC_HDR_LEN_W];
  endfunction

  // Destination field; carried through the router untouched by the arbiter.
  function automatic logic [FWNOC_HDR_DST_W-1:0] fwnoc_hdr_dst(
    input logic [FWNOC_HDR_DST_LSB+FWNOC_HDR_DST_W-1:0] hdr
  );
    return hdr[FWNOC_HDR_DST_LSB +: FWNOC_HDR_DST_W];
  endfunction

endpackage

// File: rtl/fwnoc_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. Shared by the router output stages.
module fwnoc_rr_arb
  import fwnoc_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int               idx_wide;
  logic [IDX_W-1:0] idx;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    gnt_idx  = '0;
    any      = 1'b0;
    idx_wide = 0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx_wide = (int'(ptr) + i) % N;
      idx      = IDX_W'(idx_wide);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/fwnoc_outport_arb.sv
// Packet-level (wormhole) round-robin arbiter draining N fwnoc_fifo egress
// streams into one registered output link.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | next flit from any port is a header; round-robin picks the port
// BUSY  | payload of the granted packet in flight; only port gnt is served
module fwnoc_outport_arb
  import fwnoc_pkg::*;
#(
  parameter  int N_PORTS   = 4,
  parameter  int DAT_WIDTH = 32,
  localparam int SRC_W     = $clog2(N_PORTS)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [N_PORTS-1:0]           i_valid,
  input  logic [N_PORTS*DAT_WIDTH-1:0] i_dat,
  output logic [N_PORTS-1:0]           i_ready,
  output logic                         o_valid,
  output logic [DAT_WIDTH-1:0]         o_dat,
  output logic [SRC_W-1:0]             o_src,
  input  logic                         o_ready
);

  fwnoc_arb_state_e            state, state_nxt;
  logic [SRC_W-1:0]            ptr;
  logic [SRC_W-1:0]            gnt;
  logic [FWNOC_HDR_LEN_W-1:0]  cnt;
  logic [SRC_W-1:0]            rr_sel;
  logic                        rr_any;
  logic                        can_load;
  logic                        xfer;
  logic [SRC_W-1:0]            xfer_idx;
  logic [DAT_WIDTH-1:0]        xfer_dat;
  logic [FWNOC_HDR_LEN_W-1:0]  xfer_len;

  fwnoc_rr_arb #(
    .N     (N_PORTS),
    .IDX_W (SRC_W)
  ) u_rr_arb (
    .req     (i_valid),
    .ptr     (ptr),
    .gnt_idx (rr_sel),
    .any     (rr_any)
  );

  // The output register can take a flit when empty or being drained this cycle.
  assign can_load = !o_valid || o_ready;

  // In IDLE the picker chooses the source; in BUSY the packet owner does.
  assign xfer_idx = (state == IDLE) ? rr_sel : gnt;
  assign xfer_dat = i_dat[int'(xfer_idx)*DAT_WIDTH +: DAT_WIDTH];
  assign xfer_len = fwnoc_hdr_len(xfer_dat[FWNOC_HDR_DST_LSB+FWNOC_HDR_DST_W-1:0]);

  // Next-state, per-port accept and transfer detect.
  always_comb begin
    state_nxt = state;
    i_ready   = '0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        xfer = rr_any && can_load;
        if (xfer) begin
          i_ready[rr_sel] = 1'b1;
          if (xfer_len != '0) state_nxt = BUSY;
        end
      end
      BUSY: begin
        i_ready[gnt] = can_load;
        xfer         = can_load && i_valid[gnt];
        if (xfer && cnt == FWNOC_HDR_LEN_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing is accepted while reset is held, even though the output is empty.
    if (!reset_n) begin
      i_ready = '0;
      xfer    = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Grant bookkeeping: rotate the pointer and load the length on each header.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      gnt <= '0;
      cnt <= '0;
    end else if (xfer) begin
      if (state == IDLE) begin
        ptr <= (rr_sel == SRC_W'(N_PORTS-1)) ? '0 : rr_sel + SRC_W'(1);
        gnt <= rr_sel;
        cnt <= xfer_len;
      end else begin
        cnt <= cnt - FWNOC_HDR_LEN_W'(1);
      end
    end
  end

  // Registered output link; holds its flit until the downstream accepts it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_dat   <= '0;
      o_src   <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_dat   <= xfer_dat;
      o_src   <= xfer_idx;
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fwnoc_outport_arb.sv
// Bench for fwnoc_outport_arb: directed scenarios plus a randomized run
// against a packet-level reference model.
module tb_fwnoc_outport_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic            clock;
  logic            reset_n;
  logic [N-1:0]    i_valid;
  logic [N*DW-1:0] i_dat;
  logic [N-1:0]    i_ready;
  logic            o_valid;
  logic [DW-1:0]   o_dat;
  logic [SW-1:0]   o_src;
  logic            o_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] q [N][$];
  logic [N-1:0]  en;
  logic [N-1:0]  drv_acc;

  fwnoc_outport_arb #(
    .N_PORTS   (N),
    .DAT_WIDTH (DW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (i_valid),
    .i_dat   (i_dat),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_dat   (o_dat),
    .o_src   (o_src),
    .o_ready (o_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Source driver: each port presents its queue front and holds it until accepted.
  initial begin
    drv_acc = '0;
    forever begin
      @(negedge clock);
      drv_acc = i_valid & i_ready;
      @(posedge clock);
      #1;
      for (int p = 0; p < N; p++) begin
        if (drv_acc[p] && q[p].size() > 0) void'(q[p].pop_front());
        if (!(i_valid[p] && !drv_acc[p])) begin
          if (en[p] && q[p].size() > 0) begin
            i_valid[p]          = 1'b1;
            i_dat[p*DW +: DW]   = q[p][0];
          end else begin
            i_valid[p] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int p = 0; p < N; p++) q[p].delete();
    i_valid = '0;
    en      = '0;
    o_ready = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    reset_n = 1'b0;
    i_valid = '1;
    #1;
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b required 0", o_valid); end
    n_tests++;
    if (o_dat !== '0) begin n_fail++; $display("FAIL reset_o_dat: got %h required 0", o_dat); end
    n_tests++;
    if (o_src !== '0) begin n_fail++; $display("FAIL reset_o_src: got %0d required 0", o_src); end
    n_tests++;
    if (i_ready !== '0) begin n_fail++; $display("FAIL reset_i_ready: got %b required 0000", i_ready); end
    i_valid = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_packet();
    logic [DW-1:0] exp_s [4];
    logic found;
    exp_s[0] = 32'h0000_0503; exp_s[1] = 32'h0000_00A1;
    exp_s[2] = 32'h0000_00A2; exp_s[3] = 32'h0000_00A3;
    o_ready = 1'b1;
    for (int k = 0; k < 4; k++) q[2].push_back(exp_s[k]);
    en = 4'b0100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_valid === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL single_start: o_valid never rose, required within 20 cycles"); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      n_tests++;
      if (o_valid !== 1'b1 || o_dat !== exp_s[k] || o_src !== 2'd2) begin
        n_fail++;
        $display("FAIL single_flit%0d: got v=%b dat=%h src=%0d required v=1 dat=%h src=2",
                 k, o_valid, o_dat, o_src, exp_s[k]);
      end
    end
    tick();
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_end: o_valid=%b required 0", o_valid); end
    // Pointer now at 3: port 3 must beat port 0 when both request together.
    q[0].push_back(32'h0000_0000);
    q[3].push_back(32'h0000_0900);
    en = 4'b1001;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_valid === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (o_src !== 2'd3 || o_dat !== 32'h0000_0900) begin
      n_fail++; $display("FAIL ptr_after_single: got src=%0d dat=%h required src=3 dat=00000900", o_src, o_dat);
    end
    tick();
    n_tests++;
    if (o_valid !== 1'b1 || o_src !== 2'd0 || o_dat !== 32'h0) begin
      n_fail++; $display("FAIL ptr_second: got v=%b src=%0d dat=%h required v=1 src=0 dat=0", o_valid, o_src, o_dat);
    end
    en = '0;
    repeat (2) tick();
  endtask

  task automatic test_wormhole();
    logic [DW-1:0] exp_d [4];
    logic [SW-1:0] exp_p [4];
    logic found;
    exp_d[0] = 32'h0000_0002; exp_p[0] = 2'd0;
    exp_d[1] = 32'h0000_00B1; exp_p[1] = 2'd0;
    exp_d[2] = 32'h0000_00B2; exp_p[2] = 2'd0;
    exp_d[3] = 32'h0000_0100; exp_p[3] = 2'd1;
    o_ready = 1'b1;
    for (int k = 0; k < 3; k++) q[0].push_back(exp_d[k]);
    en = 4'b0011;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_valid === 1'b1) found = 1'b1;
    end
    q[1].push_back(exp_d[3]);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      n_tests++;
      if (o_valid !== 1'b1 || o_dat !== exp_d[k] || o_src !== exp_p[k]) begin
        n_fail++;
        $display("FAIL wormhole_flit%0d: got v=%b dat=%h src=%0d required v=1 dat=%h src=%0d",
                 k, o_valid, o_dat, o_src, exp_d[k], exp_p[k]);
      end
      if (k < 2) begin
        n_tests++;
        if (i_ready[1] !== 1'b0) begin
          n_fail++; $display("FAIL wormhole_lock%0d: i_ready[1]=%b required 0", k, i_ready[1]);
        end
      end
    end
    en = '0;
    repeat (2) tick();
  endtask

  task automatic test_round_robin();
    logic found;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) q[p].push_back(DW'((r << 16) | (p << 8)));
    en = '1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_valid === 1'b1) found = 1'b1;
    end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      n_tests++;
      if (o_valid !== 1'b1 || o_src !== SW'(k % N) || o_dat !== DW'(((k / N) << 16) | ((k % N) << 8))) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got v=%b src=%0d dat=%h required v=1 src=%0d",
                 k, o_valid, o_src, o_dat, k % N);
      end
    end
    repeat (4) tick();
    en = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] c [5];
    logic found;
    c[0] = 32'h0000_0104; c[1] = 32'h0000_00C1; c[2] = 32'h0000_00C2;
    c[3] = 32'h0000_00C3; c[4] = 32'h0000_00C4;
    o_ready = 1'b1;
    for (int k = 0; k < 5; k++) q[1].push_back(c[k]);
    en = 4'b0010;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_valid === 1'b1 && o_dat === c[1]) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL bp_start: first payload never seen, required within 20 cycles"); end
    o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (i_ready !== '0) begin n_fail++; $display("FAIL bp_ready%0d: i_ready=%b required 0000", k, i_ready); end
      tick();
      n_tests++;
      if (o_valid !== 1'b1 || o_dat !== c[1] || o_src !== 2'd1) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b dat=%h src=%0d required v=1 dat=%h src=1",
                           k, o_valid, o_dat, o_src, c[1]);
      end
    end
    o_ready = 1'b1;
    for (int k = 2; k < 5; k++) begin
      tick();
      n_tests++;
      if (o_valid !== 1'b1 || o_dat !== c[k]) begin
        n_fail++; $display("FAIL bp_resume%0d: got v=%b dat=%h required v=1 dat=%h", k, o_valid, o_dat, c[k]);
      end
    end
    tick();
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end: o_valid=%b required 0", o_valid); end
    en = '0;
  endtask

  task automatic test_reset_mid_packet();
    logic found;
    o_ready = 1'b1;
    q[0].push_back(32'h0000_0004);
    for (int k = 1; k <= 4; k++) q[0].push_back(DW'(32'hD0 + k));
    en = 4'b0001;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_valid === 1'b1 && o_dat === 32'h0000_00D1) found = 1'b1;
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (o_valid !== 1'b0 || o_dat !== '0 || o_src !== '0) begin
      n_fail++; $display("FAIL rst_mid_out: got v=%b dat=%h src=%0d required all 0", o_valid, o_dat, o_src);
    end
    n_tests++;
    if (i_ready !== '0) begin n_fail++; $display("FAIL rst_mid_ready: i_ready=%b required 0000", i_ready); end
    for (int p = 0; p < N; p++) q[p].delete();
    i_valid = '0;
    en      = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    q[0].push_back(32'h0000_0700);
    en = 4'b0001;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_valid === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (o_dat !== 32'h0000_0700 || o_src !== 2'd0) begin
      n_fail++; $display("FAIL rst_hdr: got dat=%h src=%0d required dat=00000700 src=0", o_dat, o_src);
    end
    q[1].push_back(32'h0000_0800);
    en = 4'b0011;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_valid === 1'b1 && o_src === 2'd1) found = 1'b1;
    end
    n_tests++;
    if (!found || o_dat !== 32'h0000_0800) begin
      n_fail++; $display("FAIL rst_idle: port1 header got found=%b dat=%h required found=1 dat=00000800", found, o_dat);
    end
    en = '0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    int total, out_count, seq, len;
    logic exp_ov;
    logic [DW-1:0] exp_od, flit;
    logic [SW-1:0] exp_os;
    logic m_busy, can_load, g_ok;
    int m_port, m_ptr, m_rem, g, p2;
    logic [N-1:0] exp_rdy;
    do_reset();
    total = 0; seq = 0;
    for (int p = 0; p < N; p++) begin
      for (int pk = 0; pk < 4; pk++) begin
        len = $urandom_range(0, 5);
        q[p].push_back({4'(p), 12'(seq), 8'($urandom_range(0, 255)), 8'(len)});
        seq++; total++;
        for (int f = 0; f < len; f++) begin
          q[p].push_back({4'(p), 12'(seq), 16'($urandom)});
          seq++; total++;
        end
      end
    end
    exp_ov = 1'b0; exp_od = '0; exp_os = '0;
    m_busy = 1'b0; m_port = 0; m_ptr = 0; m_rem = 0;
    out_count = 0;
    for (int cyc = 0; cyc < 3000 && out_count < total; cyc++) begin
      tick();
      n_tests++;
      if (o_valid !== exp_ov || (exp_ov && (o_dat !== exp_od || o_src !== exp_os))) begin
        n_fail++;
        $display("FAIL rnd_out cyc%0d: got v=%b dat=%h src=%0d required v=%b dat=%h src=%0d",
                 cyc, o_valid, o_dat, o_src, exp_ov, exp_od, exp_os);
      end
      o_ready = ($urandom_range(0, 3) != 0);
      en      = N'($urandom);
      #1;
      can_load = !exp_ov || o_ready;
      g_ok = 1'b0; g = 0;
      if (m_busy) begin
        g = m_port; g_ok = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          p2 = (m_ptr + k) % N;
          if (!g_ok && i_valid[p2]) begin g = p2; g_ok = 1'b1; end
        end
      end
      exp_rdy = (g_ok && can_load) ? N'(1 << g) : '0;
      n_tests++;
      if (i_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rnd_ready cyc%0d: got %b required %b", cyc, i_ready, exp_rdy);
      end
      if ((i_valid & exp_rdy) != '0) begin
        flit   = i_dat[g*DW +: DW];
        exp_ov = 1'b1; exp_od = flit; exp_os = SW'(g);
        out_count++;
        if (!m_busy) begin
          m_ptr  = (g + 1) % N;
          m_port = g;
          if (flit[7:0] != 8'd0) begin m_busy = 1'b1; m_rem = int'(flit[7:0]); end
        end else begin
          m_rem--;
          if (m_rem == 0) m_busy = 1'b0;
        end
      end else if (o_ready) begin
        exp_ov = 1'b0;
      end
    end
    tick();
    n_tests++;
    if (o_valid !== exp_ov || (exp_ov && (o_dat !== exp_od || o_src !== exp_os))) begin
      n_fail++; $display("FAIL rnd_last: got v=%b dat=%h required v=%b dat=%h", o_valid, o_dat, exp_ov, exp_od);
    end
    n_tests++;
    if (out_count != total) begin
      n_fail++; $display("FAIL rnd_drain: transferred %0d flits required %0d", out_count, total);
    end
    en = '0;
    o_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    reset_n = 1'b1;
    i_valid = '0;
    i_dat   = '0;
    en      = '0;
    o_ready = 1'b0;
    test_reset();
    test_single_packet();
    test_wormhole();
    test_round_robin();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
